ram_cmd_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares the single-port SPI-slave RAM between two requester ports.
- Converts each accepted read or write transaction into the RAM's 10-bit command sequence on ram_din/ram_rx_valid: opcode in bits [9:8], payload in bits [7:0].
- Collects read data from ram_dout/ram_tx_valid and returns one response per transaction on the owning port.
- Sits between on-chip masters and the RAM block, replacing the SPI front end as the RAM's command source.

---
 rtl/ram_cmd_arbiter.sv | 219 +++++++++++++++++++++
 tb/tb_ram_cmd_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// ram_cmd_arbiter
//
// Shares the single-port SPI-slave RAM between two requester ports. Each
// accepted request is turned into the RAM's 10-bit command stream
// (opcode in [9:8], payload below it) and answered with exactly one
// response pulse on the port that issued it. Ports are served round-robin
// with one transaction in flight at a time.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   reqN_valid/we/addr/wdata      request N (N = 0,1), held until reqN_ready
//   reqN_ready                    combinational grant, request captured on edge
//   rspN_valid/rdata/err          one-cycle response; rdata held between responses
//   ram_din, ram_rx_valid         command word and strobe to the RAM
//   ram_dout, ram_tx_valid        read data returned by the RAM
//   busy                          high while a transaction is in progress
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | no transaction; grant a waiting port
// CMD_ADDR | send address command (write: op 00, read: op 10)
// CMD_DATA | send write data command (op 01), writes only
// WAIT_RD  | wait for RAM read data, bounded by TIMEOUT cycles
// RESP     | one-cycle response pulse on the owning port
// ---------------------------------------------------------------------------
module ram_cmd_arbiter #(
  parameter int ADDR_SIZE = 8,
  parameter int TIMEOUT   = 8
) (
  input  logic                 clk,
  input  logic                 rst,

  input  logic                 req0_valid,
  input  logic                 req0_we,
  input  logic [ADDR_SIZE-1:0] req0_addr,
  input  logic [7:0]           req0_wdata,
  output logic                 req0_ready,
  output logic                 rsp0_valid,
  output logic [7:0]           rsp0_rdata,
  output logic                 rsp0_err,

  input  logic                 req1_valid,
  input  logic                 req1_we,
  input  logic [ADDR_SIZE-1:0] req1_addr,
  input  logic [7:0]           req1_wdata,
  output logic                 req1_ready,
  output logic                 rsp1_valid,
  output logic [7:0]           rsp1_rdata,
  output logic                 rsp1_err,

  output logic [ADDR_SIZE+1:0] ram_din,
  output logic                 ram_rx_valid,
  input  logic [7:0]           ram_dout,
  input  logic                 ram_tx_valid,

  output logic                 busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD_ADDR,
    S_CMD_DATA,
    S_WAIT_RD,
    S_RESP
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t                 state_q, state_d;
  logic                   last_grant_q;
  logic                   owner_q;
  logic                   we_q;
  logic [ADDR_SIZE-1:0]   addr_q;
  logic [7:0]             wdata_q;
  logic [7:0]             cnt_q;
  logic                   err_q;
  logic [7:0]             rdata0_q, rdata1_q;

  logic                   grant_any;
  logic                   grant_sel;
  logic                   load_req;
  logic                   rd_done;
  logic                   rd_timeout;
  logic [7:0]             cnt_inc;

  assign cnt_inc = cnt_q + 8'd1;

  // Arbitration: a lone requester wins; on a tie the port that did not
  // win last time goes first.
  always_comb begin
    grant_any = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      grant_sel = ~last_grant_q;
    end else begin
      grant_sel = req1_valid;
    end
  end

  always_comb begin
    state_d      = state_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    ram_din      = '0;
    ram_rx_valid = 1'b0;
    load_req     = 1'b0;
    rd_done      = 1'b0;
    rd_timeout   = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Grant is suppressed while rst is high so no accept pulse is seen
        // on a cycle whose edge will discard the request.
        if (grant_any && !rst) begin
          load_req   = 1'b1;
          req0_ready = ~grant_sel;
          req1_ready = grant_sel;
          state_d    = S_CMD_ADDR;
        end
      end

      S_CMD_ADDR: begin
        ram_rx_valid = 1'b1;
        if (we_q) begin
          ram_din = {2'b00, addr_q};
          state_d = S_CMD_DATA;
        end else begin
          ram_din = {2'b10, addr_q};
          state_d = S_WAIT_RD;
        end
      end

      S_CMD_DATA: begin
        ram_rx_valid = 1'b1;
        ram_din      = {2'b01, ADDR_SIZE'(wdata_q)};
        state_d      = S_RESP;
      end

      S_WAIT_RD: begin
        ram_din = {2'b11, {ADDR_SIZE{1'b0}}};
        // The first WAIT_RD cycle (cnt_q == 0) may still show the previous
        // read's tx_valid, so it is not trusted.
        if ((cnt_q != 8'd0) && ram_tx_valid) begin
          rd_done = 1'b1;
          state_d = S_RESP;
        end else if (cnt_inc == TIMEOUT_CNT) begin
          rd_timeout = 1'b1;
          state_d    = S_RESP;
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q <= state_d;

      if (load_req) begin
        owner_q      <= grant_sel;
        last_grant_q <= grant_sel;
        we_q         <= grant_sel ? req1_we    : req0_we;
        addr_q       <= grant_sel ? req1_addr  : req0_addr;
        wdata_q      <= grant_sel ? req1_wdata : req0_wdata;
      end

      if (state_q == S_CMD_ADDR) begin
        cnt_q <= '0;
        err_q <= 1'b0;
      end

      if (state_q == S_WAIT_RD) begin
        cnt_q <= cnt_inc;
        if (rd_done) begin
          err_q <= 1'b0;
          if (owner_q) begin
            rdata1_q <= ram_dout;
          end else begin
            rdata0_q <= ram_dout;
          end
        end else if (rd_timeout) begin
          err_q <= 1'b1;
          if (owner_q) begin
            rdata1_q <= '0;
          end else begin
            rdata0_q <= '0;
          end
        end
      end
    end
  end

  assign rsp0_valid = (state_q == S_RESP) && !owner_q;
  assign rsp1_valid = (state_q == S_RESP) &&  owner_q;
  assign rsp0_err   = rsp0_valid & err_q;
  assign rsp1_err   = rsp1_valid & err_q;
  assign rsp0_rdata = rdata0_q;
  assign rsp1_rdata = rdata1_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_ram_cmd_arbiter.sv
module tb_ram_cmd_arbiter;

  localparam int ADDR_SIZE = 8;
  localparam int TIMEOUT   = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       req0_valid = 1'b0, req0_we = 1'b0;
  logic [7:0] req0_addr = '0, req0_wdata = '0;
  logic       req1_valid = 1'b0, req1_we = 1'b0;
  logic [7:0] req1_addr = '0, req1_wdata = '0;
  logic       req0_ready, req1_ready;
  logic       rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
  logic [7:0] rsp0_rdata, rsp1_rdata;
  logic [9:0] ram_din;
  logic       ram_rx_valid;
  logic [7:0] ram_dout;
  logic       ram_tx_valid;
  logic       busy;

  ram_cmd_arbiter #(.ADDR_SIZE(ADDR_SIZE), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .ram_din(ram_din), .ram_rx_valid(ram_rx_valid),
    .ram_dout(ram_dout), .ram_tx_valid(ram_tx_valid),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: commands take effect one cycle after the edge that samples
  // them, so a previous read's tx_valid/dout are still visible in the first
  // WAIT_RD cycle. tx_valid stays high until the next command is processed.
  logic [7:0] mem [256];
  logic       cmd_v = 1'b0;
  logic [9:0] cmd_w = '0;
  logic [7:0] m_addr = '0, m_dout = '0;
  logic       m_tx = 1'b0;
  logic       kill = 1'b0;

  assign ram_dout     = m_dout;
  assign ram_tx_valid = m_tx & ~kill;

  always @(posedge clk) begin
    cmd_v <= ram_rx_valid;
    cmd_w <= ram_din;
    if (cmd_v) begin
      case (cmd_w[9:8])
        2'b00: begin m_addr <= cmd_w[7:0]; m_tx <= 1'b0; end
        2'b01: begin mem[m_addr] <= cmd_w[7:0]; m_tx <= 1'b0; end
        2'b10: begin m_dout <= mem[cmd_w[7:0]]; m_tx <= 1'b1; end
        default: m_tx <= 1'b0;
      endcase
    end
  end

  typedef struct {
    int         port;
    logic [7:0] rdata;
    logic       err;
    int         due;
  } rsp_t;

  typedef struct {
    int         port;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
  } vec_t;

  rsp_t       rsp_q[$];
  logic [9:0] cmd_q[$];
  int         grant_log[$];
  int         grant_cyc[$];
  logic [7:0] model_rdata [2] = '{8'h00, 8'h00};

  int tests  = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (ram_rx_valid) begin
        if (cmd_q.size() == 0) begin
          check("cmd_unexpected", {31'b0, ram_rx_valid}, 32'd0);
        end else begin
          check("cmd_word", {22'b0, ram_din}, {22'b0, cmd_q.pop_front()});
        end
      end
      if (rsp0_valid || rsp1_valid) begin
        if (rsp_q.size() == 0) begin
          check("rsp_unexpected", {30'b0, rsp1_valid, rsp0_valid}, 32'd0);
        end else begin
          rsp_t r;
          r = rsp_q.pop_front();
          check("rsp_port", {30'b0, rsp1_valid, rsp0_valid}, (r.port == 1) ? 32'd2 : 32'd1);
          check("rsp_rdata", {24'b0, (r.port == 1) ? rsp1_rdata : rsp0_rdata}, {24'b0, r.rdata});
          check("rsp_err", {31'b0, (r.port == 1) ? rsp1_err : rsp0_err}, {31'b0, r.err});
          check("rsp_latency", cyc, r.due);
        end
      end
    end
  end

  task automatic drive(input int port, input logic v, input logic we,
                       input logic [7:0] addr, input logic [7:0] wdata);
    if (port == 0) begin
      req0_valid = v; req0_we = we; req0_addr = addr; req0_wdata = wdata;
    end else begin
      req1_valid = v; req1_we = we; req1_addr = addr; req1_wdata = wdata;
    end
  endtask

  // Raises a request, waits (bounded) for its grant, records expectations,
  // and returns at the falling edge of the cycle after the grant.
  task automatic do_req(input int port, input logic we, input logic [7:0] addr,
                        input logic [7:0] wdata, input logic [7:0] rd_exp,
                        input logic to_exp);
    int   n;
    logic rdy;
    rsp_t r;
    @(negedge clk);
    drive(port, 1'b1, we, addr, wdata);
    #1;
    n = 0;
    forever begin
      rdy = (port == 0) ? req0_ready : req1_ready;
      if (rdy || n >= 200) break;
      @(negedge clk);
      #1;
      n++;
    end
    check("grant", {31'b0, rdy}, 32'd1);
    if (rdy) begin
      check("ready_onehot", {31'b0, req0_ready & req1_ready}, 32'd0);
      grant_log.push_back(port);
      grant_cyc.push_back(cyc);
      r.port = port;
      r.err  = 1'b0;
      if (we) begin
        cmd_q.push_back({2'b00, addr});
        cmd_q.push_back({2'b01, wdata});
        r.rdata = model_rdata[port];
        r.due   = cyc + 3;
      end else begin
        cmd_q.push_back({2'b10, addr});
        r.rdata = to_exp ? 8'h00 : rd_exp;
        r.err   = to_exp;
        r.due   = to_exp ? cyc + 2 + TIMEOUT : cyc + 4;
        model_rdata[port] = r.rdata;
      end
      rsp_q.push_back(r);
    end
    @(negedge clk);
    drive(port, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      if (rsp_q.size() == 0 && cmd_q.size() == 0) break;
      @(negedge clk);
      #1;
    end
    check("drain", rsp_q.size() + cmd_q.size(), 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_ram"}, {21'b0, ram_rx_valid, ram_din}, 32'd0);
    check({tag, "_rsp"}, {28'b0, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err}, 32'd0);
    check({tag, "_rdata"}, {16'b0, rsp0_rdata, rsp1_rdata}, 32'd0);
    check({tag, "_ready"}, {30'b0, req0_ready, req1_ready}, 32'd0);
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{0, 1'b1, 8'h12, 8'hA5, 8'h00};
    vecs[1] = '{0, 1'b0, 8'h12, 8'h00, 8'hA5};
    vecs[2] = '{0, 1'b1, 8'h05, 8'h5A, 8'h00};
    vecs[3] = '{0, 1'b1, 8'h06, 8'h6B, 8'h00};
    vecs[4] = '{0, 1'b0, 8'h05, 8'h00, 8'h5A};
    vecs[5] = '{0, 1'b0, 8'h06, 8'h00, 8'h6B};
    vecs[6] = '{1, 1'b1, 8'hFF, 8'hC3, 8'h00};
    vecs[7] = '{1, 1'b0, 8'hFF, 8'h00, 8'hC3};
    vecs[8] = '{1, 1'b0, 8'h12, 8'h00, 8'hA5};
    vecs[9] = '{1, 1'b1, 8'h12, 8'h3C, 8'h00};

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b0;

    // Tie from reset: port 0 first, port 1 right after port 0's RESP
    grant_log.delete(); grant_cyc.delete();
    fork
      do_req(0, 1'b1, 8'h01, 8'h11, 8'h00, 1'b0);
      do_req(1, 1'b1, 8'h02, 8'h22, 8'h00, 1'b0);
    join
    drain();
    check("tie_first", grant_log[0], 32'd0);
    check("tie_second", grant_log[1], 32'd1);
    check("tie_gap", grant_cyc[1] - grant_cyc[0], 32'd4);

    // Tie again: port 0 again (it was not the last winner), then port 1
    grant_log.delete(); grant_cyc.delete();
    fork
      do_req(0, 1'b0, 8'h01, 8'h00, 8'h11, 1'b0);
      do_req(1, 1'b0, 8'h02, 8'h00, 8'h22, 1'b0);
    join
    drain();
    check("tie2_first", grant_log[0], 32'd0);
    check("tie2_second", grant_log[1], 32'd1);

    // Lone port 0, then a tie: port 1 must win the tie
    grant_log.delete(); grant_cyc.delete();
    do_req(0, 1'b1, 8'h03, 8'h33, 8'h00, 1'b0);
    drain();
    fork
      do_req(0, 1'b0, 8'h03, 8'h00, 8'h33, 1'b0);
      do_req(1, 1'b0, 8'h01, 8'h00, 8'h11, 1'b0);
    join
    drain();
    check("rr_after_lone", grant_log[1], 32'd1);
    check("rr_after_lone2", grant_log[2], 32'd0);

    // Table: write/read, stale tx_valid, boundary address, cross-port
    for (int i = 0; i < 10; i++) begin
      do_req(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, 1'b0);
      if (!vecs[i].we) begin
        @(negedge clk);
        #1;
        check("wait_rd_din", {21'b0, ram_rx_valid, ram_din}, 32'h300);
      end
      drain();
    end

    // Read timeout
    kill = 1'b1;
    do_req(0, 1'b0, 8'h30, 8'h00, 8'h00, 1'b1);
    drain();
    kill = 1'b0;
    @(negedge clk);
    #1;
    check("timeout_idle", {31'b0, busy}, 32'd0);

    // Reset during CMD_DATA of a write
    do_req(0, 1'b1, 8'h40, 8'h77, 8'h00, 1'b0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    #1;
    check_idle_outputs("midreset");
    rst = 1'b0;
    rsp_q.delete(); cmd_q.delete();
    model_rdata[0] = 8'h00; model_rdata[1] = 8'h00;
    grant_log.delete(); grant_cyc.delete();
    fork
      do_req(0, 1'b0, 8'h12, 8'h00, 8'h3C, 1'b0);
      do_req(1, 1'b0, 8'hFF, 8'h00, 8'hC3, 1'b0);
    join
    drain();
    check("post_reset_first", grant_log[0], 32'd0);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
